irq_collector: RTL and testbench

- Avalon-MM slave interrupt controller. It sits directly downstream of the interval timer and the other peripheral irq lines.
- The timer irq connects to irq_in[0]; the remaining sources connect to higher indices.
- Per channel, it synchronizes, edge- or level-qualifies, latches and masks each source. It drives one combined irq_out to the CPU and exposes a priority-encoded ID for fast dispatch.
- Uses the same 16-bit, 3-bit-address register interface style as the timer.

---
 rtl/irq_collector.sv | 196 +++++++++++++++++++
 tb/tb_irq_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_collector.sv
// irq_collector: Avalon-MM slave interrupt controller.
//
// Each interrupt source is optionally synchronized, then qualified as either
// rising-edge latched or level-following. It is latched into PENDING and
// gated by MASK. One combined, registered irq_out goes to the CPU. A
// priority-encoded IRQ_ID register reports the lowest pending enabled
// channel for fast dispatch.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register word address (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe (write = chipselect && ~write_n)
//   writedata   16-bit write data
//   readdata    16-bit registered read data (1-cycle latency, every cycle)
//   irq_in      NUM_IRQ active-high interrupt sources
//   irq_out     registered combined interrupt request
//
// Register map:
//   0 PENDING (R, W1C on edge channels)   1 MASK (RW)
//   2 EDGE_SEL (RW, 1 = rising edge)      3 RAW (R, synchronized levels)
//   4 IRQ_ID (R, {valid, 11'b0, id})      5 FORCE (W, edge channels)
//   6 OVF (R, W1C)                        7 reserved, reads 0
module irq_collector #(
  parameter int NUM_IRQ = 8,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [15:0]         writedata,
  output logic [15:0]         readdata,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                irq_out
);

  // Every per-channel register is kept 16 bits wide so it lines up with the
  // bus. Bits at NUM_IRQ and above are forced to zero through this mask,
  // which makes them read 0 and ignore writes.
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_IRQ) - 32'd1);

  localparam logic [2:0] A_PENDING  = 3'd0;
  localparam logic [2:0] A_MASK     = 3'd1;
  localparam logic [2:0] A_EDGE_SEL = 3'd2;
  localparam logic [2:0] A_RAW      = 3'd3;
  localparam logic [2:0] A_IRQ_ID   = 3'd4;
  localparam logic [2:0] A_FORCE    = 3'd5;
  localparam logic [2:0] A_OVF      = 3'd6;

  logic        wr_en;
  logic [15:0] wdata;
  logic [15:0] irq_wide;
  logic [15:0] s;

  logic [15:0] hist_reg;
  logic [15:0] pending_reg, pending_next;
  logic [15:0] mask_reg, mask_next;
  logic [15:0] edge_sel_reg, edge_sel_next;
  logic [15:0] ovf_reg, ovf_next;
  logic [15:0] readdata_next;
  logic        irq_out_next;

  logic [15:0] edge_event;
  logic [15:0] pend_w1c;
  logic [15:0] ovf_w1c;
  logic [15:0] force_set;
  logic [15:0] sel_chg;
  logic [15:0] active;
  logic        id_valid;
  logic [3:0]  id;

  assign wr_en    = chipselect & ~write_n;
  assign wdata    = writedata & VALID;
  assign irq_wide = 16'(irq_in);

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  generate
    if (SYNC_EN) begin : g_sync
      logic [15:0] meta_reg;
      logic [15:0] sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= '0;
          sync_reg <= '0;
        end else begin
          meta_reg <= irq_wide;
          sync_reg <= meta_reg;
        end
      end
      assign s = sync_reg & VALID;
    end else begin : g_nosync
      assign s = irq_wide & VALID;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Bus-side strobes
  // ---------------------------------------------------------------------
  // Only edge-mode channels honour PENDING W1C and FORCE. Level channels
  // track s directly, so a clear on them would just be overwritten.
  assign pend_w1c  = (wr_en && address == A_PENDING) ? (wdata & edge_sel_reg) : '0;
  assign force_set = (wr_en && address == A_FORCE)   ? (wdata & edge_sel_reg) : '0;
  assign ovf_w1c   = (wr_en && address == A_OVF)     ? wdata : '0;
  assign sel_chg   = (wr_en && address == A_EDGE_SEL) ? (wdata ^ edge_sel_reg) : '0;

  assign mask_next     = (wr_en && address == A_MASK)     ? wdata : mask_reg;
  assign edge_sel_next = (wr_en && address == A_EDGE_SEL) ? wdata : edge_sel_reg;

  // ---------------------------------------------------------------------
  // Per-channel pending / overflow logic
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_chan
      logic pend_edge;
      logic ovf_set;

      assign edge_event[gi] = s[gi] & ~hist_reg[gi] & edge_sel_reg[gi];

      // Set wins over W1C. FORCE is simply another set source.
      assign pend_edge = (pending_reg[gi] & ~pend_w1c[gi]) | edge_event[gi] | force_set[gi];

      // An event on an already-pending bit is an overflow. This does not
      // apply if that bit is being acknowledged in the same cycle.
      assign ovf_set = edge_event[gi] & pending_reg[gi] & ~pend_w1c[gi];

      // Changing a channel's mode discards its history in both registers.
      assign pending_next[gi] = VALID[gi] & ~sel_chg[gi] &
                                (edge_sel_reg[gi] ? pend_edge : s[gi]);
      assign ovf_next[gi]     = VALID[gi] & ~sel_chg[gi] &
                                ((ovf_reg[gi] & ~ovf_w1c[gi]) | ovf_set);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Priority encoder: lowest enabled pending channel
  // ---------------------------------------------------------------------
  assign active   = pending_reg & mask_reg;
  assign id_valid = |active;

  always_comb begin
    id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) begin
        id = 4'(i);
      end
    end
  end

  assign irq_out_next = id_valid;

  // ---------------------------------------------------------------------
  // Read mux (registered every cycle, independent of chipselect)
  // ---------------------------------------------------------------------
  always_comb begin
    readdata_next = '0;
    case (address)
      A_PENDING:  readdata_next = pending_reg;
      A_MASK:     readdata_next = mask_reg;
      A_EDGE_SEL: readdata_next = edge_sel_reg;
      A_RAW:      readdata_next = s;
      A_IRQ_ID:   readdata_next = {id_valid, 11'b0, id};
      A_OVF:      readdata_next = ovf_reg;
      default:    readdata_next = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg     <= '0;
      pending_reg  <= '0;
      mask_reg     <= '0;
      edge_sel_reg <= '0;
      ovf_reg      <= '0;
      readdata     <= '0;
      irq_out      <= 1'b0;
    end else begin
      hist_reg     <= s;
      pending_reg  <= pending_next;
      mask_reg     <= mask_next;
      edge_sel_reg <= edge_sel_next;
      ovf_reg      <= ovf_next;
      readdata     <= readdata_next;
      irq_out      <= irq_out_next;
    end
  end

endmodule

// File: tb/tb_irq_collector.sv
// Directed testbench for irq_collector (NUM_IRQ=8, SYNC_EN=1).
// Register reads push their expected value onto a scoreboard queue. The
// entry is popped and compared once readdata is valid.
module tb_irq_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb_exp[$];
  string       sb_tag[$];

  irq_collector #(.NUM_IRQ(8), .SYNC_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  // Advance n edges and leave time 1 unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("WR  addr=%0d data=%h", a, d);
  endtask

  task automatic sb_pop();
    logic [15:0] exp;
    string       tag;
    checks++;
    if (sb_exp.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", readdata);
    end else begin
      exp = sb_exp.pop_front();
      tag = sb_tag.pop_front();
      assert (readdata === exp)
        else begin
          errors++;
          $error("FAIL %s: observed %h expected %h", tag, readdata, exp);
        end
      $display("RD  %s addr=%0d data=%h exp=%h", tag, address, readdata, exp);
    end
  endtask

  // One-cycle read: readdata after the edge holds the pre-edge register value.
  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    address    = a;
    chipselect = 1'b1;
    tick(1);
    chipselect = 1'b0;
    sb_pop();
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    checks++;
    assert (irq_out === exp)
      else begin
        errors++;
        $error("FAIL %s: observed irq_out=%b expected %b", tag, irq_out, exp);
      end
    $display("IRQ %s irq_out=%b exp=%b", tag, irq_out, exp);
  endtask

  // Raise the given channels just before the next edge for one cycle.
  task automatic pulse(input logic [7:0] bits);
    irq_in = bits;
    tick(1);
    irq_in = 8'h00;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
    irq_in     = 8'h00;
    tick(3);
    reset = 1'b0;

    // Reset state: every address reads zero.
    chk_irq(1'b0, "reset_irq");
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 16'h0000, $sformatf("reset_addr%0d", a));
    end

    // Single edge channel 0 with latency checks.
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    pulse(8'h01);                 // edge E0 just happened
    tick(2);                      // after E2
    chk_irq(1'b0, "lat_irq_e2");
    rd(3'd0, 16'h0001, "lat_pending_e2");
    chk_irq(1'b1, "lat_irq_e3");
    wr(3'd0, 16'h0001);           // W1C
    chk_irq(1'b1, "w1c_irq_lag");
    rd(3'd0, 16'h0000, "w1c_pending");
    chk_irq(1'b0, "w1c_irq_drop");

    // Channels 2 and 5, priority ID.
    wr(3'd2, 16'h0025);
    wr(3'd1, 16'h0024);
    pulse(8'h24);
    tick(3);
    rd(3'd4, 16'h8002, "id_ch2");
    wr(3'd0, 16'h0004);
    rd(3'd4, 16'h8005, "id_ch5");
    wr(3'd1, 16'h0000);
    rd(3'd4, 16'h0000, "id_masked");
    chk_irq(1'b0, "masked_irq");
    rd(3'd0, 16'h0020, "masked_pending");

    // Overflow on channel 3.
    wr(3'd2, 16'h002D);
    pulse(8'h08);
    tick(3);
    pulse(8'h08);
    tick(3);
    rd(3'd6, 16'h0008, "ovf_ch3");
    rd(3'd0, 16'h0028, "ovf_pending");
    wr(3'd6, 16'h0008);
    rd(3'd6, 16'h0000, "ovf_w1c");
    // Edge event lands on the same edge as the PENDING W1C.
    pulse(8'h08);                 // after E0
    tick(1);                      // after E1; event live until E2
    wr(3'd0, 16'h0008);           // W1C at E2
    rd(3'd0, 16'h0028, "coinc_pending");
    rd(3'd6, 16'h0000, "coinc_ovf");

    // Level mode channel 1.
    wr(3'd1, 16'h0002);
    irq_in = 8'h02;
    tick(3);
    rd(3'd3, 16'h0002, "raw_level");
    rd(3'd0, 16'h002A, "level_pending");
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h002A, "level_w1c_ignored");
    chk_irq(1'b1, "level_irq");
    irq_in = 8'h00;
    tick(2);                      // after E1: s low
    chk_irq(1'b1, "level_irq_e1");
    rd(3'd0, 16'h002A, "level_pending_e1");
    chk_irq(1'b1, "level_irq_e2");
    rd(3'd0, 16'h0028, "level_pending_e2");
    chk_irq(1'b0, "level_irq_e3");

    // FORCE: channel 0 edge mode, channel 7 level mode.
    wr(3'd0, 16'h0028);
    rd(3'd0, 16'h0000, "pre_force_pending");
    wr(3'd5, 16'h0081);
    rd(3'd0, 16'h0001, "force_pending");
    rd(3'd5, 16'h0000, "force_reads0");
    pulse(8'h01);
    tick(3);
    rd(3'd6, 16'h0001, "force_then_edge_ovf");
    wr(3'd1, 16'h0001);
    tick(1);
    chk_irq(1'b1, "pre_reset_irq");

    // Reset mid-operation.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_irq(1'b0, "midreset_irq");
    rd(3'd0, 16'h0000, "midreset_pending");
    rd(3'd6, 16'h0000, "midreset_ovf");
    rd(3'd1, 16'h0000, "midreset_mask");
    rd(3'd2, 16'h0000, "midreset_edge_sel");

    // Bits above NUM_IRQ and address 7.
    wr(3'd1, 16'hFFFF);
    rd(3'd1, 16'h00FF, "mask_upper_ignored");
    wr(3'd7, 16'hFFFF);
    rd(3'd7, 16'h0000, "addr7_reads0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
